conv_stream_engine: RTL and testbench

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

---
 rtl/conv_pkg.sv | 8 +
 rtl/conv_stream_engine_window_buffer.sv | 23 ++
 rtl/conv_stream_engine.sv | 116 +++++++++++
 tb/tb_conv_stream_engine.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: frame state encoding, output-map size helper and math pipeline depth
package conv_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  localparam int LAT_MATH = 3;
  function automatic int out_dim(input int mapsize, input int ksize, input int stride);
    return (mapsize - ksize) / stride + 1;
  endfunction
endpackage

// File: rtl/conv_stream_engine_window_buffer.sv
// window_buffer: pixel line buffer exposing the newest KSIZE x KSIZE window, newest pixel bottom-right
module window_buffer #(
  parameter int LENGTH = 133,
  parameter int KSIZE = 5
) (
  input  logic                         clk,
  input  logic                         shift,
  input  logic signed [7:0]            pixel,
  output logic [8*KSIZE*KSIZE-1:0]     window
);
  localparam int ROW = (LENGTH - KSIZE) / (KSIZE - 1);
  logic [7:0] line [LENGTH];
  always_ff @(posedge clk)
    if (shift) begin
      line[0] <= pixel;
      for (int i = 1; i < LENGTH; i++) line[i] <= line[i-1];
    end
  for (genvar r = 0; r < KSIZE; r++) begin : g_r
    for (genvar c = 0; c < KSIZE; c++) begin : g_c
      assign window[(r*KSIZE+c)*8 +: 8] = line[(KSIZE-1-r)*ROW + KSIZE-1-c];
    end
  end
endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming 2D convolution writing one result per window to a BRAM port.
// Define CONV_RELU_EN to clamp negative results to zero in the output register.
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int MAPSIZE = 32,
  parameter int KSIZE = 5,
  parameter int STRIDE = 1,
  parameter int ACC_W = 32,
  localparam int OUT_DIM = out_dim(MAPSIZE, KSIZE, STRIDE),
  localparam int AW = (OUT_DIM*OUT_DIM > 1) ? $clog2(OUT_DIM*OUT_DIM) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [7:0]             pixel_in,
  input  logic signed [8*KSIZE*KSIZE-1:0] weights,
  input  logic signed [ACC_W-1:0]       bias,
  output logic                          mem_wr_en,
  output logic [AW-1:0]                 mem_wr_addr,
  output logic signed [ACC_W-1:0]       mem_wr_data,
  output logic                          busy,
  output logic                          all_done
);
  localparam int KK = KSIZE*KSIZE;
  localparam int CW = $clog2(MAPSIZE);
  state_t state;
  logic [CW-1:0] row, col;
  logic [AW-1:0] wr_cnt;
  logic [LAT_MATH:0] vpipe;
  logic accept, last_col, last_px, win_ok;
  logic [8*KK-1:0] window;
  logic signed [15:0] prod [KK];
  logic signed [ACC_W-1:0] rs_next [KSIZE];
  logic signed [ACC_W-1:0] row_sum [KSIZE];
  logic signed [ACC_W-1:0] tot_next, total;
  assign accept = in_valid && in_ready;
  assign last_col = col == CW'(MAPSIZE-1);
  assign last_px = last_col && row == CW'(MAPSIZE-1);
  assign win_ok = int'(row) >= KSIZE-1 && int'(col) >= KSIZE-1 &&
                  (int'(row) - (KSIZE-1)) % STRIDE == 0 && (int'(col) - (KSIZE-1)) % STRIDE == 0;
  window_buffer #(.LENGTH((KSIZE-1)*MAPSIZE + KSIZE), .KSIZE(KSIZE)) u_wb (
    .clk(clk),
    .shift(accept),
    .pixel(pixel_in),
    .window(window)
  );
  always_comb begin
    tot_next = bias;
    for (int r = 0; r < KSIZE; r++) begin
      rs_next[r] = '0;
      for (int c = 0; c < KSIZE; c++) rs_next[r] = rs_next[r] + ACC_W'(prod[r*KSIZE+c]);
      tot_next = tot_next + row_sum[r];
    end
  end
  // math stages: products, per-row sums, total plus bias
  always_ff @(posedge clk) begin
    for (int i = 0; i < KK; i++) prod[i] <= $signed(window[i*8 +: 8]) * $signed(weights[i*8 +: 8]);
    row_sum <= rs_next;
    total <= tot_next;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      wr_cnt <= '0;
      vpipe <= '0;
      in_ready <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      busy <= 1'b0;
      all_done <= 1'b0;
    end else begin
      vpipe <= {vpipe[LAT_MATH-1:0], accept && win_ok};
      mem_wr_en <= vpipe[LAT_MATH];
      all_done <= 1'b0;
      if (vpipe[LAT_MATH]) begin
        mem_wr_addr <= wr_cnt;
`ifdef CONV_RELU_EN
        mem_wr_data <= total[ACC_W-1] ? '0 : total;
`else
        mem_wr_data <= total;
`endif
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
      end
      case (state)
        IDLE: if (start) begin
          state <= STREAM;
          in_ready <= 1'b1;
          busy <= 1'b1;
          row <= '0;
          col <= '0;
          wr_cnt <= '0;
        end
        STREAM: if (accept && last_px) begin
          state <= FLUSH;
          in_ready <= 1'b0;
        end
        // DONE only once the final write has left the output register
        FLUSH: if (vpipe == '0 && !mem_wr_en) begin
          state <= DONE;
          busy <= 1'b0;
          all_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine: random-stimulus bench for stride-1 and stride-2 instances against a window-sum model
module tb_conv_stream_engine;
  localparam int M = 8, K = 3, AW = 32;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic signed [7:0] pixel_in = 0;
  logic signed [8*K*K-1:0] weights = '0;
  logic signed [AW-1:0] bias = '0;
  logic in_ready1, in_ready2, we1, we2, busy1, busy2, ad1, ad2;
  logic [5:0] addr1;
  logic [3:0] addr2;
  logic signed [AW-1:0] data1, data2;
  int checks = 0, errors = 0;
  int img [M*M];
  int w [K*K];
  int cyc = 0, ir_bad = 0, acc = 0, dn1 = 0, dn2 = 0, last_we1 = 0, done_cyc1 = 0;
  int qa1[$], qa2[$];
  logic signed [AW-1:0] qd1[$], qd2[$];

  conv_stream_engine #(.MAPSIZE(M), .KSIZE(K), .STRIDE(1), .ACC_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .pixel_in(pixel_in), .weights(weights), .bias(bias), .mem_wr_en(we1),
    .mem_wr_addr(addr1), .mem_wr_data(data1), .busy(busy1), .all_done(ad1));
  conv_stream_engine #(.MAPSIZE(M), .KSIZE(K), .STRIDE(2), .ACC_W(AW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .pixel_in(pixel_in), .weights(weights), .bias(bias), .mem_wr_en(we2),
    .mem_wr_addr(addr2), .mem_wr_data(data2), .busy(busy2), .all_done(ad2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (we1) begin qa1.push_back(int'(addr1)); qd1.push_back(data1); last_we1 = cyc; end
    if (we2) begin qa2.push_back(int'(addr2)); qd2.push_back(data2); end
    if (ad1) begin dn1++; done_cyc1 = cyc; end
    if (ad2) dn2++;
    if ((in_ready1 && (!busy1 || acc >= M*M)) || in_ready1 !== in_ready2) ir_bad++;
    acc = busy1 ? acc + int'(in_valid && in_ready1) : 0;
  end

  task automatic load(input int pix, input int wt, input int b);
    for (int i = 0; i < M*M; i++) img[i] = pix;
    for (int i = 0; i < K*K; i++) w[i] = wt;
    bias = AW'(b);
    for (int i = 0; i < K*K; i++) weights[i*8 +: 8] = 8'(w[i]);
  endtask

  task automatic stream(input int gap, input int npix);
    int i = 0, ph = 0;
    logic a;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (i < npix && ph < 4*M*M + 100) begin
      in_valid = gap != 0 ? (ph % 2 == 0) : 1'b1;
      pixel_in = 8'(img[i]);
      @(negedge clk);
      a = in_valid && in_ready1;
      @(posedge clk); #1;
      if (a) i++;
      ph++;
    end
    in_valid = 0;
    checks++;
    if (i != npix) begin errors++; $display("FAIL stream_accept: accepted %0d expected %0d", i, npix); end
  endtask

  task automatic test_frame(input string name, input int gap);
    int d1, d2, od, s, n, sum;
    int qa[$];
    logic signed [AW-1:0] qd[$];
    qa1.delete(); qa2.delete(); qd1.delete(); qd2.delete();
    d1 = dn1; d2 = dn2;
    stream(gap, M*M);
    in_valid = gap != 0;
    pixel_in = 8'sh7f;
    for (int t = 0; t < 200 && (dn1 == d1 || dn2 == d2); t++) @(negedge clk);
    repeat (10) @(negedge clk);
    in_valid = 0;
    checks++;
    if (dn1 != d1 + 1 || dn2 != d2 + 1) begin
      errors++; $display("FAIL %s all_done_count: got %0d/%0d expected 1/1", name, dn1 - d1, dn2 - d2);
    end
    checks++;
    if (done_cyc1 <= last_we1) begin
      errors++; $display("FAIL %s done_after_write: done cycle %0d last write %0d", name, done_cyc1, last_we1);
    end
    for (int k = 0; k < 2; k++) begin
      s = k + 1;
      od = (M - K) / s + 1;
      if (k == 0) begin qa = qa1; qd = qd1; end else begin qa = qa2; qd = qd2; end
      n = qa.size();
      checks++;
      if (n != od*od) begin errors++; $display("FAIL %s s%0d write_count: got %0d expected %0d", name, s, n, od*od); end
      for (int i = 0; i < n && i < od*od; i++) begin
        sum = int'(bias);
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            sum += img[((i/od)*s + r)*M + (i%od)*s + c] * w[r*K + c];
`ifdef CONV_RELU_EN
        if (sum < 0) sum = 0;
`endif
        checks++;
        if (qa[i] != i || qd[i] !== sum) begin
          errors++;
          $display("FAIL %s s%0d write%0d: got addr %0d data %0d expected addr %0d data %0d", name, s, i, qa[i], qd[i], i, sum);
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready1, we1, addr1, data1, busy1, ad1, in_ready2, we2, addr2, data2, busy2, ad2} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs expected all 0");
    end
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy %b in_ready %b expected 0 0", busy1, in_ready1);
    end
  endtask

  task automatic test_ones;
    load(1, 1, 0);
    test_frame("ones", 0);
  endtask

  task automatic test_negative;
    load(1, -1, 2);
    test_frame("negative", 0);
  endtask

  task automatic test_gaps;
    load(1, 1, 0);
    test_frame("gaps", 1);
  endtask

  task automatic test_random;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < M*M; i++) img[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < K*K; i++) w[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < K*K; i++) weights[i*8 +: 8] = 8'(w[i]);
      bias = AW'(int'($urandom_range(0, 200000)) - 100000);
      test_frame("random", f % 2);
    end
  endtask

  task automatic test_abort;
    load(1, 1, 0);
    stream(0, 30);
    rst_n = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready1, we1, addr1, data1, busy1, ad1, in_ready2, we2, addr2, data2, busy2, ad2} !== '0) begin
        errors++; $display("FAIL abort_reset_outputs: got nonzero outputs expected all 0");
      end
    end
    @(posedge clk); #1;
    rst_n = 1;
    test_frame("after_abort", 0);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_negative();
    test_gaps();
    test_random();
    test_abort();
    checks++;
    if (ir_bad != 0) begin errors++; $display("FAIL in_ready_outside_stream: got %0d bad cycles expected 0", ir_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
